ram_port_arbiter: RTL

- Sequences and shares the single cache-to-RAM port between I-cache refill (read-only) and D-cache refill/writeback (read or write).
- Sits between both cache controllers and main memory.
- Arbitrates round-robin and holds the port for one owner per transaction.
- Supports a D-cache lock so that a writeback and its refill run back-to-back.
- Bounds every RAM transaction with a response timeout.

---
 rtl/ram_port_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin owner of the single cache-to-RAM port shared by I-cache and D-cache refills/writebacks
module ram_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_done,
    output logic [LINE_W-1:0] rdata,
    output logic              bus_err,
    output logic              grant_d,
    output logic              enable_cache_to_ram,
    output logic              write_cache_to_ram,
    output logic [ADDR_W-1:0] addr_cache_to_ram,
    output logic [LINE_W-1:0] wdata_cache_to_ram,
    input  logic              response_ram_to_cache,
    input  logic [LINE_W-1:0] rdata_ram_to_cache
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic              grant_d_q, grant_d_d;
    logic              rr_last_q, rr_last_d;
    logic              lock_q, lock_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              err_q, err_d;
    logic              pick_d, pick_i, expire;

    // Arbitration: a held lock or a lone/fair D request picks D, else I; expiry of the response window
    always_comb begin
        pick_d = d_req && (lock_q || !i_req || !rr_last_q);
        pick_i = i_req && !pick_d;
        expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    // Next state: grant opens a transaction, acknowledge or expiry closes it, DONE is a single cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (pick_d || pick_i) ? BUSY : IDLE;
            BUSY:    state_d = (response_ram_to_cache || expire) ? DONE : BUSY;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath: latch the owner's request at grant, complete on acknowledge or timeout
    always_comb begin
        grant_d_d = grant_d_q;
        rr_last_d = rr_last_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (lock_q && !d_req) lock_d = 1'b0;
                if (pick_d || pick_i) begin
                    en_d      = 1'b1;
                    grant_d_d = pick_d;
                    rr_last_d = pick_d;
                    we_d      = pick_d && d_we;
                    addr_d    = pick_d ? d_addr : i_addr;
                    wdata_d   = pick_d ? d_wdata : '0;
                    cnt_d     = '0;
                    if (pick_d) lock_d = d_lock;
                end
            end
            BUSY: begin
                if (response_ram_to_cache) begin
                    en_d     = 1'b0;
                    i_done_d = !grant_d_q;
                    d_done_d = grant_d_q;
                    if (!we_q) rdata_d = rdata_ram_to_cache;
                end else if (expire) begin
                    en_d     = 1'b0;
                    i_done_d = !grant_d_q;
                    d_done_d = grant_d_q;
                    err_d    = 1'b1;
                    lock_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State register; reset drops the port request at once and issues no completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Datapath and output registers; rr_last resets to D so the I-cache wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_d_q <= 1'b0;
            rr_last_q <= 1'b1;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            grant_d_q <= grant_d_d;
            rr_last_q <= rr_last_d;
            lock_q    <= lock_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            err_q     <= err_d;
        end
    end

    assign i_done              = i_done_q;
    assign d_done              = d_done_q;
    assign rdata               = rdata_q;
    assign bus_err             = err_q;
    assign grant_d             = grant_d_q;
    assign enable_cache_to_ram = en_q;
    assign write_cache_to_ram  = we_q;
    assign addr_cache_to_ram   = addr_q;
    assign wdata_cache_to_ram  = wdata_q;
endmodule
